mux_2level_cfgchain_tapbuf: RTL and testbench



---
 rtl/mux_2level_cfgchain_tapbuf.sv | 116 +++++++++++
 tb/tb_mux_2level_cfgchain_tapbuf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2level_cfgchain_tapbuf.sv
// Two-level one-hot routing mux with its own serial configuration chain.
// New words are shifted into a shadow register and committed atomically, so the data path never sees a partial select.
module mux_2level_cfgchain_tapbuf #(
  parameter int NUM_INPUTS = 8,
  parameter int BASIS_SIZE = 4,
  localparam int SEL_W      = $clog2(NUM_INPUTS),
  localparam int CFG_W      = SEL_W + 1,
  localparam int NUM_GROUPS = (NUM_INPUTS + BASIS_SIZE - 1) / BASIS_SIZE
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  ccff_head,
  input  logic                  cfg_shift_en,
  input  logic                  cfg_commit,
  output logic                  ccff_tail,
  output logic                  cfg_full,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic [NUM_INPUTS-1:0] in,
  output logic                  out,
  output logic [BASIS_SIZE-1:0] mem_l1,
  output logic [BASIS_SIZE-1:0] mem_l1_inv,
  output logic [NUM_GROUPS-1:0] mem_l2,
  output logic [NUM_GROUPS-1:0] mem_l2_inv
);

  localparam int                CNT_W    = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CFG_W);
  localparam int                PAD_W    = 2 ** SEL_W;

  typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_FULL} state_e;

  logic [CFG_W-1:0] shift_q, shift_d;
  logic [CFG_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  state_e           state;
  logic             sel_ok;

  always_comb begin
    if (cnt_q == '0)            state = ST_EMPTY;
    else if (cnt_q == CNT_FULL) state = ST_FULL;
    else                        state = ST_LOADING;
  end

  assign sel_ok = int'(shift_q[SEL_W-1:0]) < NUM_INPUTS;

  // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    shift_d  = shift_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = err_q;
    if (cfg_shift_en && cfg_commit) begin
      err_d = 1'b1;
    end else if (cfg_shift_en) begin
      shift_d = {shift_q[CFG_W-2:0], ccff_head};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (cfg_commit) begin
      if (state == ST_FULL && sel_ok) begin
        active_d = shift_q;
        cnt_d    = '0;
        done_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      shift_q  <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail = shift_q[CFG_W-1];
  assign cfg_full  = (state == ST_FULL);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  logic [SEL_W-1:0] act_sel;
  logic             act_en;
  logic [PAD_W-1:0] in_pad;

  assign act_sel = active_q[SEL_W-1:0];
  assign act_en  = active_q[CFG_W-1];
  // Zero-padding keeps the index in range when NUM_INPUTS is not a power of two.
  assign in_pad  = PAD_W'(in);
  assign out     = act_en & in_pad[act_sel];

  always_comb begin
    mem_l1 = '0;
    mem_l2 = '0;
    for (int m = 0; m < BASIS_SIZE; m++)
      mem_l1[m] = act_en && ((int'(act_sel) % BASIS_SIZE) == m);
    for (int g = 0; g < NUM_GROUPS; g++)
      mem_l2[g] = act_en && ((int'(act_sel) / BASIS_SIZE) == g);
  end

  assign mem_l1_inv = ~mem_l1;
  assign mem_l2_inv = ~mem_l2;

endmodule

// File: tb/tb_mux_2level_cfgchain_tapbuf.sv
// Scoreboard bench: an 8-input and a 6-input instance share clock and reset and are checked against a behavioural model.
module tb_mux_2level_cfgchain_tapbuf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_head, a_sh, a_cm, b_head, b_sh, b_cm;
  logic [7:0] a_in;
  logic [5:0] b_in;
  logic       a_tail, a_full, a_done, a_err, a_out;
  logic       b_tail, b_full, b_done, b_err, b_out;
  logic [3:0] a_l1, a_l1i, b_l1, b_l1i;
  logic [1:0] a_l2, a_l2i, b_l2, b_l2i;

  mux_2level_cfgchain_tapbuf #(.NUM_INPUTS(8), .BASIS_SIZE(4)) dut_a (
    .prog_clk(clk), .pReset_n(rst_n), .ccff_head(a_head), .cfg_shift_en(a_sh),
    .cfg_commit(a_cm), .ccff_tail(a_tail), .cfg_full(a_full), .cfg_done(a_done),
    .cfg_err(a_err), .in(a_in), .out(a_out), .mem_l1(a_l1), .mem_l1_inv(a_l1i),
    .mem_l2(a_l2), .mem_l2_inv(a_l2i));

  mux_2level_cfgchain_tapbuf #(.NUM_INPUTS(6), .BASIS_SIZE(4)) dut_b (
    .prog_clk(clk), .pReset_n(rst_n), .ccff_head(b_head), .cfg_shift_en(b_sh),
    .cfg_commit(b_cm), .ccff_tail(b_tail), .cfg_full(b_full), .cfg_done(b_done),
    .cfg_err(b_err), .in(b_in), .out(b_out), .mem_l1(b_l1), .mem_l1_inv(b_l1i),
    .mem_l2(b_l2), .mem_l2_inv(b_l2i));

  // Both instances have a 4-bit config word: {enable, sel[2:0]}.
  typedef struct {
    logic [3:0] sh;
    logic [3:0] act;
    int         cnt;
    logic       done;
    logic       err;
  } mdl_t;

  typedef struct {
    logic       out, tail, full, done, err;
    logic [3:0] l1, l1i;
    logic [1:0] l2, l2i;
  } exp_t;

  mdl_t ma, mb;
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.sh = '0; r.act = '0; r.cnt = 0; r.done = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int n_in, logic head, logic sh, logic cm);
    mdl_t r = m;
    r.done = 1'b0;
    if (sh && cm) r.err = 1'b1;
    else if (sh) begin
      r.sh = {m.sh[2:0], head};
      if (m.cnt < 4) r.cnt = m.cnt + 1;
    end else if (cm) begin
      if (m.cnt == 4 && int'(m.sh[2:0]) < n_in) begin
        r.act = m.sh; r.cnt = 0; r.done = 1'b1;
      end else r.err = 1'b1;
    end
    return r;
  endfunction

  function automatic exp_t predict(mdl_t m, logic [7:0] din);
    exp_t e;
    int   sel = int'(m.act[2:0]);
    logic en  = m.act[3];
    e.out  = en & din[sel];
    e.tail = m.sh[3];
    e.full = (m.cnt == 4);
    e.done = m.done;
    e.err  = m.err;
    e.l1 = '0; e.l2 = '0;
    if (en) begin
      e.l1[sel % 4] = 1'b1;
      e.l2[sel / 4] = 1'b1;
    end
    e.l1i = ~e.l1;
    e.l2i = ~e.l2;
    return e;
  endfunction

  function automatic exp_t observe(int d);
    exp_t o;
    if (d == 0) begin
      o.out = a_out; o.tail = a_tail; o.full = a_full; o.done = a_done; o.err = a_err;
      o.l1 = a_l1; o.l1i = a_l1i; o.l2 = a_l2; o.l2i = a_l2i;
    end else begin
      o.out = b_out; o.tail = b_tail; o.full = b_full; o.done = b_done; o.err = b_err;
      o.l1 = b_l1; o.l1i = b_l1i; o.l2 = b_l2; o.l2i = b_l2i;
    end
    return o;
  endfunction

  task automatic push_expect(input int d);
    if (d == 0) sb_q.push_back(predict(ma, a_in));
    else        sb_q.push_back(predict(mb, {2'b00, b_in}));
  endtask

  task automatic compare(input string tag, input int d);
    exp_t e, o;
    if (sb_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    o = observe(d);
    check({tag, "/out"},  8'(o.out),  8'(e.out));
    check({tag, "/tail"}, 8'(o.tail), 8'(e.tail));
    check({tag, "/full"}, 8'(o.full), 8'(e.full));
    check({tag, "/done"}, 8'(o.done), 8'(e.done));
    check({tag, "/err"},  8'(o.err),  8'(e.err));
    check({tag, "/l1"},   8'(o.l1),   8'(e.l1));
    check({tag, "/l1i"},  8'(o.l1i),  8'(e.l1i));
    check({tag, "/l2"},   8'(o.l2),   8'(e.l2));
    check({tag, "/l2i"},  8'(o.l2i),  8'(e.l2i));
  endtask

  task automatic idle_inputs();
    a_head = 1'b0; a_sh = 1'b0; a_cm = 1'b0;
    b_head = 1'b0; b_sh = 1'b0; b_cm = 1'b0;
  endtask

  // One clock cycle on instance d; the other instance idles and its model advances too.
  task automatic step(input string tag, input int d, input logic head, input logic sh, input logic cm);
    @(negedge clk);
    idle_inputs();
    if (d == 0) begin a_head = head; a_sh = sh; a_cm = cm; end
    else        begin b_head = head; b_sh = sh; b_cm = cm; end
    ma = mdl_next(ma, 8, a_head, a_sh, a_cm);
    mb = mdl_next(mb, 6, b_head, b_sh, b_cm);
    push_expect(d);
    @(posedge clk);
    #1;
    compare(tag, d);
    idle_inputs();
  endtask

  task automatic shift_word(input string tag, input int d, input logic [3:0] w);
    for (int i = 3; i >= 0; i--) step(tag, d, w[i], 1'b1, 1'b0);
  endtask

  // Combinational check with no clock edge in between.
  task automatic probe(input string tag, input int d);
    push_expect(d);
    #1;
    compare(tag, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    a_in = 8'hA5;
    b_in = 6'h2A;
    rst_n = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    probe("rst_a", 0);
    probe("rst_b", 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Program enable=1, sel=5 and watch the done pulse.
    shift_word("a_ld5", 0, 4'b1101);
    step("a_cm5", 0, 1'b0, 1'b0, 1'b1);
    step("a_idle", 0, 1'b0, 1'b0, 1'b0);
    foreach (sb_q[i]) ;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] pats [4] = '{8'h00, 8'h20, 8'hDF, 8'hFF};
      a_in = pats[i];
      probe("a_data5", 0);
    end

    // Short load: commit with three bits rejected, the fourth bit makes it legal.
    a_in = 8'h5A;
    step("a_s3", 0, 1'b1, 1'b1, 1'b0);
    step("a_s3", 0, 1'b0, 1'b1, 1'b0);
    step("a_s3", 0, 1'b1, 1'b1, 1'b0);
    step("a_cm_short", 0, 1'b0, 1'b0, 1'b1);
    step("a_s4", 0, 1'b0, 1'b1, 1'b0);
    step("a_cm2", 0, 1'b0, 1'b0, 1'b1);
    step("a_cm_b2b", 0, 1'b0, 1'b0, 1'b1);

    // 6-input instance: legal sel=3, then sel=7 is out of range.
    b_in = 6'b001000;
    shift_word("b_ld3", 1, 4'b1011);
    step("b_cm3", 1, 1'b0, 1'b0, 1'b1);
    shift_word("b_ld7", 1, 4'b1111);
    step("b_cm7", 1, 1'b0, 1'b0, 1'b1);
    b_in = 6'b110111;
    probe("b_data3", 1);

    // Reset between edges after two shift bits.
    step("a_pre_rst", 0, 1'b1, 1'b1, 1'b0);
    step("a_pre_rst", 0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    probe("a_rst_mid", 0);
    probe("b_rst_mid", 1);
    @(negedge clk);
    rst_n = 1'b1;
    a_in = 8'h80;
    shift_word("a_ld7", 0, 4'b1111);
    step("a_cm7", 0, 1'b0, 1'b0, 1'b1);

    // Simultaneous shift and commit while full: flagged, nothing moves.
    shift_word("b_ld2", 1, 4'b1010);
    step("b_shcm", 1, 1'b1, 1'b1, 1'b1);
    b_in = 6'b000100;
    step("b_cm2", 1, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
